// File: rtl/serial_rx_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_rx_buffer_pkg
// Description : Shared UART constants and the receive-buffer controller state
//               type. The serial receiver, a future transmitter and the
//               receive buffer all import these so that the bit timing and
//               the byte width can never drift apart between blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_rx_buffer_pkg;

    // System clocks per UART bit at 57600 baud (25 MHz system clock).
    localparam int c_CLOCKS_WAIT = 434;

    // Payload width of one 8N1 frame.
    localparam int c_DATA_WIDTH  = 8;

    // Receive controller: the first ready edge after reset is the receiver
    // announcing idle, not a byte, so it only arms the buffer.
    typedef enum logic [0:0] {
        UNARMED = 1'b0,
        ARMED   = 1'b1
    } ctrlState_t;

endpackage : serial_rx_buffer_pkg
`default_nettype wire

// File: rtl/serial_rx_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : serial_rx_fifo_mem
// Description : DEPTH x DATA_WIDTH register array used as the FIFO storage of
//               the serial receive buffer. One synchronous write port, one
//               asynchronous (combinational) read port. Contents are not
//               reset; validity is tracked by the owning buffer.
// Ports       : CLK       - system clock
//               wrEn      - write enable, sampled at the rising edge
//               wrAddr    - write address
//               wrData    - write data
//               rdAddr    - read address
//               rdData    - combinational read data at rdAddr
// Revision    : 1.0 - initial release
// ============================================================================
module serial_rx_fifo_mem
    import serial_rx_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = c_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  wrEn,
    input  logic [ADDR_WIDTH-1:0] wrAddr,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic [ADDR_WIDTH-1:0] rdAddr,
    output logic [DATA_WIDTH-1:0] rdData
);

    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    always_ff @(posedge CLK) begin
        if (wrEn) begin
            r_mem[wrAddr] <= wrData;
        end
    end

    assign rdData = r_mem[rdAddr];

endmodule : serial_rx_fifo_mem
`default_nettype wire

// File: rtl/serial_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : serial_rx_buffer
// Description : Receive-side byte FIFO sitting directly behind the UART
//               receiver. A rising edge on the receiver's ready line marks a
//               completed byte, which is pushed into a DEPTH-entry FIFO. The
//               oldest byte is presented show-ahead to the consumer, and a
//               sticky flag records any byte dropped because the FIFO was
//               full.
// Ports       : CLK               - system clock (receiver clock domain)
//               RESET             - synchronous active-high reset
//               IN_RX_DATA        - received byte, stable while ready is high
//               IN_RX_READY       - receiver idle/ready, rises on byte loaded
//               IN_POP            - consumer removes the head byte
//               IN_CLEAR_OVERFLOW - clears OUT_OVERFLOW
//               OUT_DATA          - head byte, 0 when empty
//               OUT_VALID         - FIFO not empty
//               OUT_FULL          - FIFO holds DEPTH bytes
//               OUT_COUNT         - number of stored bytes, 0..DEPTH
//               OUT_OVERFLOW      - sticky dropped-byte flag
// Revision    : 1.0 - initial release
// ============================================================================
module serial_rx_buffer
    import serial_rx_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = c_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] IN_RX_DATA,
    input  logic                  IN_RX_READY,
    input  logic                  IN_POP,
    input  logic                  IN_CLEAR_OVERFLOW,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  OUT_VALID,
    output logic                  OUT_FULL,
    output logic [ADDR_WIDTH:0]   OUT_COUNT,
    output logic                  OUT_OVERFLOW
);

    // Count value meaning "full": only the MSB set, i.e. 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0]   c_DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   c_CNT_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE   = ADDR_WIDTH'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    ctrlState_t              r_state;
    ctrlState_t              w_stateNext;
    logic                    r_readyQ;
    logic [ADDR_WIDTH-1:0]   r_wrPtr;
    logic [ADDR_WIDTH-1:0]   r_rdPtr;
    logic [ADDR_WIDTH:0]     r_count;
    logic                    r_overflow;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic                    w_rxEdge;
    logic                    w_pushReq;
    logic                    w_popDo;
    logic                    w_pushDo;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_overflowEvt;
    logic [DATA_WIDTH-1:0]   w_memRdData;

    assign w_rxEdge = IN_RX_READY & ~r_readyQ;
    assign w_full   = (r_count == c_DEPTH_CNT);
    assign w_empty  = (r_count == '0);

    // A pop on an empty FIFO is silently ignored.
    assign w_popDo  = IN_POP & ~w_empty;

    // When full, a simultaneous pop frees a slot this same cycle, so the
    // push is still accepted and no overflow is raised.
    assign w_pushDo      = w_pushReq & (~w_full | w_popDo);
    assign w_overflowEvt = w_pushReq & w_full & ~w_popDo;

    // ------------------------------------------------------------------------
    // Arming controller
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= UNARMED;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_pushReq   = 1'b0;
        case (r_state)
            UNARMED: begin
                // The receiver's post-reset idle announcement carries no byte.
                if (w_rxEdge) begin
                    w_stateNext = ARMED;
                end
            end
            ARMED: begin
                w_pushReq = w_rxEdge;
            end
            default: begin
                w_stateNext = UNARMED;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Ready edge register, pointers, count and overflow flag
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_readyQ <= 1'b0;
        end else begin
            r_readyQ <= IN_RX_READY;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            // Pointers wrap DEPTH-1 -> 0 by natural overflow of ADDR_WIDTH.
            if (w_pushDo) begin
                r_wrPtr <= r_wrPtr + c_PTR_ONE;
            end
            if (w_popDo) begin
                r_rdPtr <= r_rdPtr + c_PTR_ONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_count <= '0;
        end else begin
            case ({w_pushDo, w_popDo})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_overflow <= 1'b0;
        end else if (w_overflowEvt) begin
            // A new drop beats a clear requested in the same cycle.
            r_overflow <= 1'b1;
        end else if (IN_CLEAR_OVERFLOW) begin
            r_overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    serial_rx_fifo_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .CLK    (CLK),
        .wrEn   (w_pushDo),
        .wrAddr (r_wrPtr),
        .wrData (IN_RX_DATA),
        .rdAddr (r_rdPtr),
        .rdData (w_memRdData)
    );

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Unwritten memory is never exposed: an empty FIFO reads as zero.
    assign OUT_DATA     = w_empty ? '0 : w_memRdData;
    assign OUT_VALID    = ~w_empty;
    assign OUT_FULL     = w_full;
    assign OUT_COUNT    = r_count;
    assign OUT_OVERFLOW = r_overflow;

endmodule : serial_rx_buffer
`default_nettype wire

// File: tb/tb_serial_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_rx_buffer
// Description : Self-checking bench for serial_rx_buffer. Directed scenarios
//               followed by randomized traffic, all compared every cycle
//               against a queue-based reference model of the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_rx_buffer;

    localparam int c_DEPTH = 16;

    logic       CLK;
    logic       RESET;
    logic [7:0] rxData;
    logic       rxReady;
    logic       pop;
    logic       clearOvf;
    logic [7:0] outData;
    logic       outValid;
    logic       outFull;
    logic [4:0] outCount;
    logic       outOverflow;

    serial_rx_buffer #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (8)
    ) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .IN_RX_DATA        (rxData),
        .IN_RX_READY       (rxReady),
        .IN_POP            (pop),
        .IN_CLEAR_OVERFLOW (clearOvf),
        .OUT_DATA          (outData),
        .OUT_VALID         (outValid),
        .OUT_FULL          (outFull),
        .OUT_COUNT         (outCount),
        .OUT_OVERFLOW      (outOverflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ------------------------------------------------------------------------
    // Reference model: a byte queue plus a few flags
    // ------------------------------------------------------------------------
    logic [7:0] mQ[$];
    bit         mArmed;
    bit         mPrevReady;
    bit         mOvf;

    int nChecks = 0;
    int nErrors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkModel(input string tag);
        logic [7:0] expData;
        int         sz;
        sz      = mQ.size();
        expData = (sz > 0) ? mQ[0] : 8'h00;
        check({tag, ".count"},    32'(outCount),    32'(sz));
        check({tag, ".valid"},    32'(outValid),    32'(sz > 0));
        check({tag, ".full"},     32'(outFull),     32'(sz == c_DEPTH));
        check({tag, ".overflow"}, 32'(outOverflow), 32'(mOvf));
        check({tag, ".data"},     32'(outData),     32'(expData));
    endtask

    // One clock cycle: drive inputs, advance the model, compare after the edge.
    task automatic step(input logic rst, input logic rdy, input logic [7:0] d,
                        input logic p, input logic clr, input string tag);
        bit edgeSeen;
        bit pushReq;
        bit popOk;
        bit ovfEvt;
        @(negedge CLK);
        RESET    = rst;
        rxReady  = rdy;
        rxData   = d;
        pop      = p;
        clearOvf = clr;
        if (rst) begin
            mQ.delete();
            mArmed     = 0;
            mPrevReady = 0;
            mOvf       = 0;
        end else begin
            edgeSeen   = rdy && !mPrevReady;
            mPrevReady = rdy;
            pushReq    = edgeSeen && mArmed;
            if (edgeSeen && !mArmed) mArmed = 1;
            popOk  = p && (mQ.size() > 0);
            ovfEvt = 0;
            if (popOk) void'(mQ.pop_front());
            if (pushReq) begin
                if (mQ.size() < c_DEPTH) mQ.push_back(d);
                else ovfEvt = 1;
            end
            if (ovfEvt) mOvf = 1;
            else if (clr) mOvf = 0;
        end
        @(posedge CLK);
        #1;
        checkModel(tag);
    endtask

    task automatic sendByte(input logic [7:0] d, input logic p, input logic clr, input string tag);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, {tag, ".low"});
        step(1'b0, 1'b1, d, p, clr, tag);
    endtask

    task automatic popOne(input string tag);
        step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, tag);
    endtask

    task automatic doReset(input string tag);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, tag);
    endtask

    initial begin
        RESET    = 1'b1;
        rxReady  = 1'b0;
        rxData   = 8'h00;
        pop      = 1'b0;
        clearOvf = 1'b0;

        // Reset state
        doReset("reset");
        check("reset.data_const", 32'(outData), 32'h0);
        check("reset.count_const", 32'(outCount), 32'h0);

        // Arming: first ready edge stores nothing
        sendByte(8'h00, 1'b0, 1'b0, "arm");
        check("arm.valid_const", 32'(outValid), 32'h0);

        // Single byte after a long low period
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "single.low");
        step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, "single.push");
        check("single.data_const", 32'(outData), 32'hA5);
        check("single.count_const", 32'(outCount), 32'h1);
        popOne("single.pop");
        check("single.empty_const", 32'(outValid), 32'h0);

        // Order and pointer wrap
        for (int i = 1; i <= 16; i++) sendByte(8'(i), 1'b0, 1'b0, "wrap.fill");
        check("wrap.full_const", 32'(outFull), 32'h1);
        for (int i = 0; i < 8; i++) popOne("wrap.pop8");
        check("wrap.notfull_const", 32'(outFull), 32'h0);
        for (int i = 17; i <= 24; i++) sendByte(8'(i), 1'b0, 1'b0, "wrap.refill");
        for (int i = 0; i < 16; i++) begin
            check("wrap.order_const", 32'(outData), 32'(8'h09 + i));
            popOne("wrap.drain");
        end

        // Overflow: the 17th byte is dropped
        for (int i = 1; i <= 16; i++) sendByte(8'(i), 1'b0, 1'b0, "ovf.fill");
        sendByte(8'h99, 1'b0, 1'b0, "ovf.drop");
        check("ovf.flag_const", 32'(outOverflow), 32'h1);
        check("ovf.head_const", 32'(outData), 32'h01);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, "ovf.clear");
        check("ovf.cleared_const", 32'(outOverflow), 32'h0);

        // Full + push + pop: accepted, no overflow
        sendByte(8'h55, 1'b1, 1'b0, "simul.fullpushpop");
        check("simul.full_count_const", 32'(outCount), 32'd16);
        check("simul.full_noovf_const", 32'(outOverflow), 32'h0);

        // Clear and overflow together: overflow wins
        sendByte(8'h66, 1'b0, 1'b1, "simul.clrovf");
        check("simul.clrovf_const", 32'(outOverflow), 32'h1);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("simul.last55_const", 32'(outData), 32'h55);
            popOne("simul.drain");
        end
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, "simul.clear");

        // Empty + push + pop: pop ignored
        sendByte(8'h33, 1'b1, 1'b0, "simul.emptypushpop");
        check("simul.empty_data_const", 32'(outData), 32'h33);

        // Reset in the middle of operation
        for (int i = 0; i < 4; i++) sendByte(8'($urandom), 1'b0, 1'b0, "rst.fill");
        check("rst.five_const", 32'(outCount), 32'd5);
        doReset("rst.pulse");
        check("rst.count_const", 32'(outCount), 32'h0);
        sendByte(8'h12, 1'b0, 1'b0, "rst.rearm");
        check("rst.absorbed_const", 32'(outCount), 32'h0);
        sendByte(8'h7E, 1'b0, 1'b0, "rst.first");
        check("rst.data_const", 32'(outData), 32'h7E);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 2) != 0),
                 8'($urandom),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 19) == 0),
                 "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule : tb_serial_rx_buffer
`default_nettype wire

// File: doc/serial_rx_buffer.md
Name: serial_rx_buffer

Overview:
Receive-side byte buffer placed directly downstream of the UART serial receiver (57600 baud, 8N1, LSB-first).
- Detects each completed byte from the receiver's ready/data pair and pushes it into a DEPTH-entry FIFO.
- Presents the oldest byte to the consumer (command decoder / host logic) through a show-ahead pop interface.
- Keeps a sticky overflow flag so bursts longer than the buffer are detectable.

Parameters:
ADDR_WIDTH, 4, FIFO address bits; DEPTH = 2**ADDR_WIDTH (16 by default).
DATA_WIDTH, 8, byte width; fixed at 8 for the UART path.

Ports:
CLK  input  1  system clock, same domain as the serial receiver.
RESET  input  1  synchronous, active-high reset.
IN_RX_DATA  input  8  byte from the receiver; stable whenever IN_RX_READY=1.
IN_RX_READY  input  1  receiver idle/ready; low while a frame is in progress, returns high once the new byte is loaded.
IN_POP  input  1  consumer removes the head byte at this clock edge.
IN_CLEAR_OVERFLOW  input  1  clears OUT_OVERFLOW.
OUT_DATA  output  8  head byte, or 0 when empty.
OUT_VALID  output  1  FIFO not empty.
OUT_FULL  output  1  count == DEPTH.
OUT_COUNT  output  ADDR_WIDTH+1  number of stored bytes, 0..DEPTH.
OUT_OVERFLOW  output  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset values: OUT_VALID=0, OUT_FULL=0, OUT_COUNT=0, OUT_OVERFLOW=0, OUT_DATA=0.
  - Pointers, count, ready_q and armed also reset to 0.
  - Memory contents are not reset.
- Edge detect:
  - ready_q is a registered copy of IN_RX_READY.
  - rx_edge = IN_RX_READY & ~ready_q, evaluated in the same cycle.
- Arming:
  - The receiver raises ready once after reset with no byte received.
  - The first rx_edge after RESET only sets armed=1 and pushes nothing.
  - Every later rx_edge is a push request that samples IN_RX_DATA in that cycle.
- Push latency: a request in cycle N writes at the end of cycle N.
  - OUT_VALID, OUT_COUNT and OUT_DATA reflect the byte in cycle N+1.
- Show-ahead read:
  - OUT_DATA = mem[rd_ptr] when count>0, else 0.
  - Combinational from rd_ptr and memory.
- Pop: IN_POP with count>0 advances rd_ptr at the clock edge.
  - IN_POP with count==0 is ignored; no state change.
- Pointers are ADDR_WIDTH bits and wrap DEPTH-1 -> 0 naturally.
  - Full and empty are derived from count, not from pointer comparison.
- Simultaneous push and pop:
  - count>0: both happen and count is unchanged, including when full.
    - With count==DEPTH, the push is accepted because a slot frees that cycle.
    - No overflow in this case.
  - count==0: the pop is ignored, the push is accepted, count becomes 1.
- Overflow: a push request with count==DEPTH and no valid pop drops the byte.
  - Memory and pointers are unchanged.
  - OUT_OVERFLOW is set the next cycle.
- OUT_OVERFLOW stays 1 until IN_CLEAR_OVERFLOW or RESET.
  - If a clear and a new overflow occur in the same cycle, the overflow wins and the flag stays 1.
- RESET mid-frame: all state is discarded, including armed.
  - The receiver re-announces idle after its own reset, and the arming rule absorbs that edge.
- Controller states:
  - UNARMED: first rx_edge -> ARMED.
  - ARMED: rx_edge -> push request; stays in ARMED.
  - RESET -> UNARMED from any state.
- count arithmetic: ADDR_WIDTH+1 bits. +1 on push only, -1 on pop only, unchanged on both or neither; never exceeds DEPTH.

Decomposition:
- Shared include file holds the UART constants: CLOCKS_WAIT=434 for 57600 baud and DATA_WIDTH=8.
  - The receiver, a future transmitter and this buffer use the same constants.
- One sub-module, serial_rx_fifo_mem: a DEPTH x 8 register array with one synchronous write port and one asynchronous read port.
- Edge detect, arming, pointers, count and overflow logic stay in serial_rx_buffer.

Test Plan:
- Arming: RESET, then IN_RX_READY 0 -> 1 with IN_RX_DATA=0x00 -> OUT_VALID stays 0, OUT_COUNT=0.
- Single byte: after arming, drop ready for 10 cycles, raise it with data 0xA5 -> cycle+1: OUT_VALID=1, OUT_DATA=0xA5, OUT_COUNT=1; IN_POP -> next cycle OUT_VALID=0, OUT_DATA=0.
- Order and wrap: push 0x01..0x10 (16 bytes), pop 8, push 0x11..0x18 -> pops return 0x09..0x18 in order; OUT_FULL=1 exactly when OUT_COUNT=16.
- Overflow: fill with 16 bytes, push 0x99 -> count stays 16, OUT_OVERFLOW=1, head still 0x01, 0x99 never appears.
  - Then IN_CLEAR_OVERFLOW -> 0.
- Simultaneous events:
  - Full + push 0x55 + pop -> count 16, no overflow, 0x55 is last out.
  - Empty + push 0x33 + pop -> count 1, OUT_DATA=0x33.
  - Clear + overflow in the same cycle -> OUT_OVERFLOW=1.
- Reset mid-operation: 5 bytes stored, assert RESET for 1 cycle -> all outputs 0.
  - The next ready rising edge is absorbed by arming; the following edge with 0x7E yields OUT_DATA=0x7E, count 1.
